rv0_ct_ctrl: RTL and testbench

//  Control-transfer sequencer between the execute stage and fetch. Takes resolved JAL/JALR/BRANCH

---
 rtl/rv0_ct_ctrl.sv | 117 +++++++++++
 tb/tb_rv0_ct_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv0_ct_ctrl.sv
// Control-transfer sequencer: flags mispredicts and misaligned targets from execute,
// then drives a one-cycle flush plus either a fetch redirect or an exception handoff.
module rv0_ct_ctrl #(
  parameter int XLEN   = 32,
  parameter int IALIGN = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  output logic             ex_ready_o,
  input  logic             ex_is_ct_i,
  input  logic [XLEN-1:0]  ex_addr_i,
  input  logic             ex_ct_trans_i,
  input  logic [XLEN-1:0]  ex_ct_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [XLEN-1:0]  ex_pred_target_i,
  output logic             flush_o,
  output logic             fe_redir_valid_o,
  input  logic             fe_redir_ready_i,
  output logic [XLEN-1:0]  fe_redir_addr_o,
  output logic             exc_valid_o,
  input  logic             exc_ready_i,
  output logic [3:0]       exc_cause_o,
  output logic [XLEN-1:0]  exc_tval_o,
  output logic [CNT_W-1:0] ct_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o
);

  // state | meaning
  // IDLE  | accepting resolved instructions from execute
  // REDIR | holding a fetch redirect until fetch takes it
  // EXC   | holding a misaligned-target exception until the trap unit takes it
  typedef enum logic [1:0] {IDLE, REDIR, EXC} state_t;

  localparam bit CHK_ALIGN = (IALIGN == 32);

  state_t           state_q, state_d;
  logic             ready_q, ready_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [XLEN-1:0]  tval_q, tval_d;
  logic [CNT_W-1:0] ct_q, ct_d;
  logic [CNT_W-1:0] mis_q, mis_d;

  logic accept;
  logic misalign;
  logic mispred;

  assign accept   = ex_valid_i & ready_q & ex_is_ct_i;
  assign misalign = ex_ct_trans_i & CHK_ALIGN & ex_ct_target_i[1];
  assign mispred  = (ex_ct_trans_i != ex_pred_taken_i) |
                    (ex_ct_trans_i & ex_pred_taken_i & (ex_ct_target_i != ex_pred_target_i));

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    addr_d  = addr_q;
    tval_d  = tval_q;
    ct_d    = ct_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ct_q != '1) ct_d = ct_q + CNT_W'(1);
          if (misalign || mispred) begin
            flush_d = 1'b1;
            if (mis_q != '1) mis_d = mis_q + CNT_W'(1);
          end
          if (misalign) begin
            state_d = EXC;
            tval_d  = ex_ct_target_i;
          end else if (mispred) begin
            state_d = REDIR;
            addr_d  = ex_ct_trans_i ? ex_ct_target_i : ex_addr_i + XLEN'(4);
          end
        end
      end
      REDIR:   if (fe_redir_ready_i) state_d = IDLE;
      EXC:     if (exc_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low while reset is asserted.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      flush_q <= 1'b0;
      addr_q  <= '0;
      tval_q  <= '0;
      ct_q    <= '0;
      mis_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      flush_q <= flush_d;
      addr_q  <= addr_d;
      tval_q  <= tval_d;
      ct_q    <= ct_d;
      mis_q   <= mis_d;
    end
  end

  assign ex_ready_o       = ready_q;
  assign flush_o          = flush_q;
  assign fe_redir_valid_o = (state_q == REDIR);
  assign fe_redir_addr_o  = addr_q;
  assign exc_valid_o      = (state_q == EXC);
  assign exc_cause_o      = 4'd0;
  assign exc_tval_o       = tval_q;
  assign ct_cnt_o         = ct_q;
  assign mispred_cnt_o    = mis_q;

endmodule

// File: tb/tb_rv0_ct_ctrl.sv
// Bench for rv0_ct_ctrl: three instances (default, IALIGN=16, CNT_W=4) share stimulus and
// are compared every cycle against a transaction-level model, plus literal spot checks.
module tb_rv0_ct_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_is_ct = 1'b0;
  logic [31:0] ex_addr = '0;
  logic        ex_trans = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_pt = 1'b0;
  logic [31:0] ex_ptarget = '0;
  logic        fe_ready = 1'b1;
  logic        exc_ready = 1'b1;

  logic        rdy[3], flush[3], rv[3], ev[3];
  logic [31:0] raddr[3], tval[3];
  logic [3:0]  cause[3];
  logic [15:0] ct0, ct1, mis0, mis1;
  logic [3:0]  ct2, mis2;
  logic [15:0] ctv[3], misv[3];

  always #5 clk = ~clk;

  always_comb begin
    ctv[0] = ct0;  ctv[1] = ct1;  ctv[2] = {12'd0, ct2};
    misv[0] = mis0; misv[1] = mis1; misv[2] = {12'd0, mis2};
  end

  rv0_ct_ctrl #(.XLEN(32), .IALIGN(32), .CNT_W(16)) u_d0 (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid), .ex_ready_o(rdy[0]),
    .ex_is_ct_i(ex_is_ct), .ex_addr_i(ex_addr), .ex_ct_trans_i(ex_trans),
    .ex_ct_target_i(ex_target), .ex_pred_taken_i(ex_pt), .ex_pred_target_i(ex_ptarget),
    .flush_o(flush[0]), .fe_redir_valid_o(rv[0]), .fe_redir_ready_i(fe_ready),
    .fe_redir_addr_o(raddr[0]), .exc_valid_o(ev[0]), .exc_ready_i(exc_ready),
    .exc_cause_o(cause[0]), .exc_tval_o(tval[0]), .ct_cnt_o(ct0), .mispred_cnt_o(mis0));

  rv0_ct_ctrl #(.XLEN(32), .IALIGN(16), .CNT_W(16)) u_d1 (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid), .ex_ready_o(rdy[1]),
    .ex_is_ct_i(ex_is_ct), .ex_addr_i(ex_addr), .ex_ct_trans_i(ex_trans),
    .ex_ct_target_i(ex_target), .ex_pred_taken_i(ex_pt), .ex_pred_target_i(ex_ptarget),
    .flush_o(flush[1]), .fe_redir_valid_o(rv[1]), .fe_redir_ready_i(fe_ready),
    .fe_redir_addr_o(raddr[1]), .exc_valid_o(ev[1]), .exc_ready_i(exc_ready),
    .exc_cause_o(cause[1]), .exc_tval_o(tval[1]), .ct_cnt_o(ct1), .mispred_cnt_o(mis1));

  rv0_ct_ctrl #(.XLEN(32), .IALIGN(32), .CNT_W(4)) u_d2 (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid), .ex_ready_o(rdy[2]),
    .ex_is_ct_i(ex_is_ct), .ex_addr_i(ex_addr), .ex_ct_trans_i(ex_trans),
    .ex_ct_target_i(ex_target), .ex_pred_taken_i(ex_pt), .ex_pred_target_i(ex_ptarget),
    .flush_o(flush[2]), .fe_redir_valid_o(rv[2]), .fe_redir_ready_i(fe_ready),
    .fe_redir_addr_o(raddr[2]), .exc_valid_o(ev[2]), .exc_ready_i(exc_ready),
    .exc_cause_o(cause[2]), .exc_tval_o(tval[2]), .ct_cnt_o(ct2), .mispred_cnt_o(mis2));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each instance holds at most one outstanding action (0 none, 1 redirect, 2 exception).
  localparam int IA[3]   = '{32, 16, 32};
  localparam int CMAX[3] = '{65535, 65535, 15};
  int          m_kind[3];
  logic [31:0] m_addr[3];
  bit          m_ready[3], m_flush[3];
  int          m_ct[3], m_mis[3];

  function automatic int kind_of(input int ia);
    if (ex_trans && ia == 32 && ex_target[1]) return 2;
    if (ex_trans != ex_pt) return 1;
    if (ex_trans && ex_pt && ex_target != ex_ptarget) return 1;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        m_kind[i] = 0; m_addr[i] = '0; m_ready[i] = 0; m_flush[i] = 0;
        m_ct[i] = 0; m_mis[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int k;
        m_flush[i] = 0;
        if (m_kind[i] == 1 && fe_ready) m_kind[i] = 0;
        else if (m_kind[i] == 2 && exc_ready) m_kind[i] = 0;
        else if (ex_valid && m_ready[i] && ex_is_ct) begin
          k = kind_of(IA[i]);
          m_ct[i] = (m_ct[i] < CMAX[i]) ? m_ct[i] + 1 : m_ct[i];
          if (k != 0) begin
            m_mis[i]   = (m_mis[i] < CMAX[i]) ? m_mis[i] + 1 : m_mis[i];
            m_flush[i] = 1;
            m_kind[i]  = k;
            if (k == 2) m_addr[i] = ex_target;
            else m_addr[i] = ex_trans ? ex_target : ex_addr + 32'd4;
          end
        end
        m_ready[i] = (m_kind[i] == 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_ni) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("ready[%0d]", i), 32'(rdy[i]), 32'(m_ready[i]));
        chk($sformatf("flush[%0d]", i), 32'(flush[i]), 32'(m_flush[i]));
        chk($sformatf("redir_valid[%0d]", i), 32'(rv[i]), 32'(m_kind[i] == 1));
        chk($sformatf("exc_valid[%0d]", i), 32'(ev[i]), 32'(m_kind[i] == 2));
        chk($sformatf("exc_cause[%0d]", i), 32'(cause[i]), 32'd0);
        if (m_kind[i] == 1) chk($sformatf("redir_addr[%0d]", i), raddr[i], m_addr[i]);
        if (m_kind[i] == 2) chk($sformatf("exc_tval[%0d]", i), tval[i], m_addr[i]);
        chk($sformatf("ct_cnt[%0d]", i), 32'(ctv[i]), 32'(m_ct[i]));
        chk($sformatf("mispred_cnt[%0d]", i), 32'(misv[i]), 32'(m_mis[i]));
      end
    end
  end

  // Waits (bounded) for all instances to be ready, then presents one instruction for one cycle.
  task automatic send(input bit ct, input logic [31:0] a, input bit tr, input logic [31:0] tg,
                      input bit pt, input logic [31:0] ptg);
    int n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got 0, expected 1 (t=%0t)", $time);
    end
    ex_valid = 1; ex_is_ct = ct; ex_addr = a; ex_trans = tr; ex_target = tg;
    ex_pt = pt; ex_ptarget = ptg;
    @(negedge clk);
    ex_valid = 0;
  endtask

  task automatic chk_zero0(input string tag);
    chk({tag, "_ready"}, 32'(rdy[0]), 32'd0);
    chk({tag, "_flush"}, 32'(flush[0]), 32'd0);
    chk({tag, "_rv"}, 32'(rv[0]), 32'd0);
    chk({tag, "_raddr"}, raddr[0], 32'd0);
    chk({tag, "_ev"}, 32'(ev[0]), 32'd0);
    chk({tag, "_tval"}, tval[0], 32'd0);
    chk({tag, "_ct"}, 32'(ct0), 32'd0);
    chk({tag, "_mis"}, 32'(mis0), 32'd0);
  endtask

  initial begin
    #2 rst_ni = 0;
    #1 chk_zero0("rst");
    repeat (2) @(negedge clk);
    rst_ni = 1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy[0]), 32'd1);

    // 1: correctly predicted not-taken branch
    send(1, 32'h100, 0, 32'h0, 0, 32'h0);
    chk("t1_flush", 32'(flush[0]), 32'd0);
    chk("t1_ready", 32'(rdy[0]), 32'd1);
    chk("t1_ct", 32'(ct0), 32'd1);
    chk("t1_mis", 32'(mis0), 32'd0);

    // 2: taken mispredict, fetch stalls three cycles
    fe_ready = 0;
    send(1, 32'h100, 1, 32'h80, 0, 32'h0);
    chk("t2_flush", 32'(flush[0]), 32'd1);
    chk("t2_ready", 32'(rdy[0]), 32'd0);
    for (int c = 2; c <= 4; c++) begin
      chk("t2_rv", 32'(rv[0]), 32'd1);
      chk("t2_raddr", raddr[0], 32'h80);
      @(negedge clk);
      chk("t2_flush_once", 32'(flush[0]), 32'd0);
    end
    chk("t2_rv4", 32'(rv[0]), 32'd1);
    chk("t2_ready4", 32'(rdy[0]), 32'd0);
    fe_ready = 1;
    @(negedge clk);
    chk("t2_ready_after", 32'(rdy[0]), 32'd1);
    chk("t2_rv_after", 32'(rv[0]), 32'd0);
    chk("t2_mis", 32'(mis0), 32'd1);

    // 3: predicted-taken but not taken, then fall-through wrap
    send(1, 32'h200, 0, 32'h0, 1, 32'h1F0);
    chk("t3_raddr", raddr[0], 32'h204);
    send(1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h40);
    chk("t3_wrap", raddr[0], 32'h0);
    chk("t3_wrap_rv", 32'(rv[0]), 32'd1);

    // 4: misaligned JALR target
    send(1, 32'h300, 1, 32'h1002, 0, 32'h0);
    chk("t4_ev", 32'(ev[0]), 32'd1);
    chk("t4_tval", tval[0], 32'h1002);
    chk("t4_no_redir", 32'(rv[0]), 32'd0);
    chk("t4_ia16_rv", 32'(rv[1]), 32'd1);
    chk("t4_ia16_addr", raddr[1], 32'h1002);
    chk("t4_ia16_ev", 32'(ev[1]), 32'd0);

    // extra directed cases
    send(1, 32'h300, 1, 32'h340, 1, 32'h340);
    chk("x_hit_flush", 32'(flush[0]), 32'd0);
    send(1, 32'h300, 1, 32'h340, 1, 32'h344);
    chk("x_wrong_tgt", raddr[0], 32'h340);
    send(0, 32'h310, 1, 32'h999, 0, 32'h0);
    chk("x_nonct_flush", 32'(flush[0]), 32'd0);
    send(1, 32'h400, 0, 32'h402, 1, 32'h402);
    chk("x_nt_misalign_rv", 32'(rv[0]), 32'd1);
    chk("x_nt_misalign_addr", raddr[0], 32'h404);

    // 5: saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) send(1, 32'h1000 + 32'(i * 4), 1, 32'h2000, 0, 32'h0);
    @(negedge clk);
    chk("t5_ct_sat", 32'(ct2), 32'd15);
    chk("t5_mis_sat", 32'(mis2), 32'd15);
    chk("t5_ct_wide", 32'(ct0), 32'd28);
    chk("t5_mis_wide", 32'(mis0), 32'd26);

    // 6: reset during a pending redirect
    fe_ready = 0;
    send(1, 32'h500, 1, 32'h600, 0, 32'h0);
    @(negedge clk);
    #2 rst_ni = 0;
    #1 chk_zero0("t6");
    @(negedge clk);
    rst_ni = 1;
    fe_ready = 1;
    @(negedge clk);
    chk("t6_ready", 32'(rdy[0]), 32'd1);
    chk("t6_ct", 32'(ct0), 32'd0);
    chk("t6_mis", 32'(mis0), 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
